mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between three requesters: VGA line fetch, PS2 key-code
//  store and CPU load/store. It sits between the memory wrapper's port 2 and the requesters.
//  Requesters use a req/ack handshake. Every access takes a fixed 4-cycle sequence.
//  Priority is fixed, with a starvation guard so the CPU is always eventually served.
// PARAMETERS
//  ADDR_W    10  memory address width
//  DATA_W    16  memory data width
//  MAX_WAIT  4   consecutive lost arbitrations after which the CPU is forced to win (>=1)
// PORTS
//  clk        in   1       system clock; all state updates on its rising edge
//  reset      in   1       asynchronous, active-low reset
//  vga_req    in   1       VGA read request; level, held until vga_ack
//  vga_addr   in   ADDR_W  VGA read address
//  vga_ack    out  1       1-cycle pulse: vga_rdata valid
//  vga_rdata  out  DATA_W  captured read data
//  kb_req     in   1       key-code write request; level, held until kb_ack
//  kb_addr    in   ADDR_W  key-code write address
//  kb_data    in   8       key code; written zero-extended to DATA_W
//  kb_ack     out  1       1-cycle pulse: write done
//  cpu_req    in   1       CPU request; level, held until cpu_ack
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU store data
//  cpu_ack    out  1       1-cycle pulse: load data valid or store done
//  cpu_rdata  out  DATA_W  captured load data
//  mem_addr   out  ADDR_W  memory address
//  mem_we     out  1       memory write enable
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; synchronous, valid 1 cycle after mem_addr
//  busy       out  1       1 when state != IDLE
//  owner      out  2       00 none, 01 VGA, 10 KB, 11 CPU
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, owner=00, all acks=0, mem_we=0, mem_addr=0,
//    mem_wdata=0, vga_rdata=0, cpu_rdata=0, cpu_wait=0. Takes effect immediately,
//    including mid-access. The aborted access is never acked and never resumed.
//  - FSM: IDLE -> ACCESS -> WAIT -> ACK -> IDLE. Leave IDLE only if at least one req=1.
//  - IDLE: arbitrate. If cpu_req && cpu_wait==MAX_WAIT, the CPU wins. Otherwise the winner
//    is VGA > KB > CPU. At the edge, latch owner, address, write data and write flag.
//  - ACCESS: drive mem_addr and mem_wdata from the latched values. mem_we=1 for exactly
//    this one cycle, and only when the owner is KB or CPU with cpu_we=1.
//  - WAIT: mem_rdata is valid. At the edge, capture it into vga_rdata (VGA owner) or
//    cpu_rdata (CPU load). The other rdata register holds its value.
//  - ACK: the owner's ack=1 for this one cycle only. Acks are registered outputs and
//    mutually exclusive.
//  - Back-to-back accesses: a new grant is possible in the IDLE cycle right after ACK.
//    Throughput is 1 access per 4 cycles.
//  - Handshake:
//    - A requester deasserts req at the edge that ends its ack cycle, so it is low in IDLE.
//    - A req dropped before grant is legal and yields no access.
//    - After grant, req/addr/data changes are ignored; values are latched in IDLE.
//  - Inputs are sampled only in IDLE. Requests arriving during an access wait for the
//    next IDLE.
//  - cpu_wait: updated only in IDLE cycles that grant.
//    - +1 when cpu_req=1 and another requester wins; saturates at MAX_WAIT.
//    - Cleared to 0 when the CPU is granted or cpu_req=0.
//  - mem_addr and mem_wdata hold their last values outside ACCESS. mem_we=0 outside ACCESS.
//  - busy = (state != IDLE). owner = 00 in IDLE, else the latched winner.
// TESTING
//  1. CPU load, cpu_addr=0x005, mem[5]=0xBEEF: grant at cycle 0; mem_addr=0x005 at cycle 1;
//     mem_we=0 throughout; cpu_ack=1 at cycle 3 only; cpu_rdata=0xBEEF.
//  2. vga_req, kb_req and cpu_req rise in the same cycle: service order VGA, KB, CPU;
//     grants at cycles 0, 4 and 8; each ack appears once.
//  3. vga_req held high continuously (re-asserted after each ack) with cpu_req=1,
//     MAX_WAIT=4: VGA wins 4 grants; the CPU is granted on the 5th; cpu_wait then returns to 0.
//  4. kb_addr=0x3FF, kb_data=0x1C: in ACCESS, mem_addr=0x3FF, mem_wdata=0x001C and mem_we=1
//     for exactly 1 cycle; kb_ack pulses once; vga_rdata and cpu_rdata are unchanged.
//  5. reset=0 asserted during WAIT of a CPU load: all outputs return to reset values without
//     waiting for a clock edge; no cpu_ack. After release with cpu_req=1, a fresh 4-cycle
//     access completes.
//  6. cpu_req pulsed for 1 cycle during a VGA access, low again before IDLE: no CPU access,
//     no cpu_ack, cpu_wait stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous data-memory port between VGA, PS2 and CPU requesters.
// Every access is a fixed IDLE/ACCESS/WAIT/ACK sequence with a CPU starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              kb_req,
    input  logic [ADDR_W-1:0] kb_addr,
    input  logic [7:0]        kb_data,
    output logic              kb_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        owner
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_VGA  = 2'b01;
    localparam logic [1:0] OWN_KB   = 2'b10;
    localparam logic [1:0] OWN_CPU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_owner;
    logic              r_is_wr;
    logic [CW-1:0]     r_cpu_wait;

    logic              w_any;
    logic              w_cpu_force;
    logic [1:0]        w_win;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic [CW-1:0]     w_wait_nx;

    assign w_any       = vga_req | kb_req | cpu_req;
    assign w_cpu_force = cpu_req && (r_cpu_wait == CW'(MAX_WAIT));

    // Starvation guard overrides the fixed VGA > KB > CPU order.
    always_comb begin
        w_win = OWN_NONE;
        if (w_cpu_force)
            w_win = OWN_CPU;
        else if (vga_req)
            w_win = OWN_VGA;
        else if (kb_req)
            w_win = OWN_KB;
        else if (cpu_req)
            w_win = OWN_CPU;
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        unique case (w_win)
            OWN_VGA: begin
                w_addr = vga_addr;
            end
            OWN_KB: begin
                w_addr  = kb_addr;
                w_wdata = {{(DATA_W-8){1'b0}}, kb_data};
                w_we    = 1'b1;
            end
            OWN_CPU: begin
                w_addr  = cpu_addr;
                w_wdata = cpu_wdata;
                w_we    = cpu_we;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    always_comb begin
        w_wait_nx = r_cpu_wait;
        if (!cpu_req || w_win == OWN_CPU)
            w_wait_nx = '0;
        else if (r_cpu_wait != CW'(MAX_WAIT))
            w_wait_nx = r_cpu_wait + 1'b1;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = w_any ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   w_next = S_ACK;
            S_ACK:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory-side outputs are registered so they appear exactly in ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_NONE;
            r_is_wr    <= 1'b0;
            r_cpu_wait <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            vga_ack    <= 1'b0;
            kb_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            vga_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            mem_we  <= 1'b0;
            vga_ack <= 1'b0;
            kb_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_win;
                        r_is_wr    <= w_we;
                        r_cpu_wait <= w_wait_nx;
                        mem_addr   <= w_addr;
                        mem_wdata  <= w_wdata;
                        mem_we     <= w_we;
                    end
                end
                S_ACCESS: begin
                    mem_we <= 1'b0;
                end
                S_WAIT: begin
                    if (r_owner == OWN_VGA)
                        vga_rdata <= mem_rdata;
                    if (r_owner == OWN_CPU && !r_is_wr)
                        cpu_rdata <= mem_rdata;
                    vga_ack <= (r_owner == OWN_VGA);
                    kb_ack  <= (r_owner == OWN_KB);
                    cpu_ack <= (r_owner == OWN_CPU);
                end
                S_ACK: begin
                    r_owner <= OWN_NONE;
                end
                default: begin
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign owner = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: memory model, ack scoreboard, per-feature tasks.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_ack;
    logic [DW-1:0] vga_rdata;
    logic          kb_req = 1'b0;
    logic [AW-1:0] kb_addr = '0;
    logic [7:0]    kb_data = '0;
    logic          kb_ack;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .kb_req(kb_req), .kb_addr(kb_addr), .kb_data(kb_data),
        .kb_ack(kb_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [15:0] init_val(input logic [9:0] a);
        return (a == 10'h005) ? 16'hBEEF : (16'hA000 ^ {6'b0, a});
    endfunction

    logic [15:0] mem [0:1023];
    bit loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i[9:0]);
            loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  own;
        logic        chk;
        logic [15:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] g_own[$];
    int         g_cyc[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_busy = 1'b0;
    logic       vga_hold = 1'b0;

    // Grant log and ack scoreboard.
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] a_own;
        logic [15:0] a_dat;
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                g_own.push_back(owner);
                g_cyc.push_back(cyc - 1);
            end
            prev_busy = busy;
            if (vga_ack || kb_ack || cpu_ack) begin
                a_own = vga_ack ? 2'd1 : (kb_ack ? 2'd2 : 2'd3);
                a_dat = vga_ack ? vga_rdata : cpu_rdata;
                checks++;
                if (2'(vga_ack) + 2'(kb_ack) + 2'(cpu_ack) != 2'd1) begin
                    errors++;
                    $display("FAIL ack_onehot got %b%b%b exp one-hot",
                             vga_ack, kb_ack, cpu_ack);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack got owner %0d exp none", a_own);
                end else begin
                    e = sb.pop_front();
                    if (a_own !== e.own || (e.chk && a_dat !== e.data)) begin
                        errors++;
                        $display("FAIL sb_ack got own %0d data %h exp own %0d data %h",
                                 a_own, a_dat, e.own, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (vga_ack && !vga_hold) vga_req = 1'b0;
        if (kb_ack) kb_req = 1'b0;
        if (cpu_ack) cpu_req = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || sb.size() != 0) && n < lim) begin
            step();
            n++;
        end
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL timeout got busy %0b pending %0d exp idle 0",
                     busy, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if ({busy, owner, vga_ack, kb_ack, cpu_ack, mem_we} !== 7'd0) begin
            errors++;
            $display("FAIL rst_ctrl got %b exp 0",
                     {busy, owner, vga_ack, kb_ack, cpu_ack, mem_we});
        end
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_mem got %h %h exp 0", mem_addr, mem_wdata);
        end
        if ({vga_rdata, cpu_rdata} !== 32'd0) begin
            errors++;
            $display("FAIL rst_rdata got %h %h exp 0", vga_rdata, cpu_rdata);
        end
        if (dut.r_cpu_wait !== 3'd0) begin
            errors++;
            $display("FAIL rst_wait got %0d exp 0", dut.r_cpu_wait);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_cpu_load();
        int c0;
        step();
        c0 = cyc;
        g_own.delete();
        g_cyc.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        sb.push_back('{2'd3, 1'b1, 16'hBEEF});
        for (int c = 1; c <= 4; c++) begin
            step();
            checks += 3;
            if (busy !== (c <= 3)) begin
                errors++;
                $display("FAIL load_busy c%0d got %b exp %b", c, busy, c <= 3);
            end
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL load_we c%0d got %b exp 0", c, mem_we);
            end
            if (cpu_ack !== (c == 3)) begin
                errors++;
                $display("FAIL load_ack c%0d got %b exp %b", c, cpu_ack, c == 3);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 10'h005 || owner !== 2'd3) begin
                    errors++;
                    $display("FAIL load_addr got %h own %0d exp 005 own 3",
                             mem_addr, owner);
                end
            end
        end
        checks += 2;
        if (cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL load_rdata got %h exp beef", cpu_rdata);
        end
        if (g_cyc.size() != 1 || g_cyc[0] != c0) begin
            errors++;
            $display("FAIL load_grant got %0d grants exp 1 at %0d", g_cyc.size(), c0);
        end
    endtask

    task automatic test_priority();
        int c0;
        step();
        c0 = cyc;
        g_own.delete();
        g_cyc.delete();
        vga_req = 1'b1; vga_addr = 10'd10;
        kb_req = 1'b1; kb_addr = 10'd20; kb_data = 8'h5A;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd30; cpu_wdata = 16'h1234;
        sb.push_back('{2'd1, 1'b1, 16'hA00A});
        sb.push_back('{2'd2, 1'b0, 16'h0000});
        sb.push_back('{2'd3, 1'b0, 16'h0000});
        wait_idle(30);
        checks++;
        if (g_own.size() != 3) begin
            errors++;
            $display("FAIL prio_count got %0d exp 3", g_own.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (g_own[i] !== 2'(i + 1) || g_cyc[i] != c0 + 4 * i) begin
                    errors++;
                    $display("FAIL prio_grant%0d got own %0d cyc %0d exp own %0d cyc %0d",
                             i, g_own[i], g_cyc[i], i + 1, c0 + 4 * i);
                end
            end
        end
        checks += 2;
        if (mem[20] !== 16'h005A || mem[30] !== 16'h1234) begin
            errors++;
            $display("FAIL prio_writes got %h %h exp 005a 1234", mem[20], mem[30]);
        end
        if (cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_rdata got %h exp beef", cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        int  max_w = 0;
        bit  done = 1'b0;
        step();
        g_own.delete();
        g_cyc.delete();
        vga_hold = 1'b1;
        vga_req = 1'b1; vga_addr = 10'd40;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd41;
        for (int i = 0; i < 4; i++) sb.push_back('{2'd1, 1'b1, 16'hA028});
        sb.push_back('{2'd3, 1'b1, 16'hA029});
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (int'(dut.r_cpu_wait) > max_w) max_w = int'(dut.r_cpu_wait);
            if (cpu_ack) begin
                done = 1'b1;
                vga_hold = 1'b0;
                vga_req = 1'b0;
            end
        end
        checks += 2;
        if (!done) begin
            errors++;
            $display("FAIL starve_timeout got no cpu_ack exp cpu_ack");
        end
        if (max_w != MW) begin
            errors++;
            $display("FAIL starve_maxwait got %0d exp %0d", max_w, MW);
        end
        checks++;
        if (g_own.size() != 5) begin
            errors++;
            $display("FAIL starve_count got %0d exp 5", g_own.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (g_own[i] !== ((i == 4) ? 2'd3 : 2'd1)) begin
                    errors++;
                    $display("FAIL starve_own%0d got %0d exp %0d",
                             i, g_own[i], (i == 4) ? 3 : 1);
                end
            end
        end
        step();
        step();
        checks += 2;
        if (dut.r_cpu_wait !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear got %0d exp 0", dut.r_cpu_wait);
        end
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL starve_idle got busy %b pending %0d exp 0 0",
                     busy, sb.size());
        end
    endtask

    task automatic test_kb_write();
        int n_we = 0;
        int n_ack = 0;
        step();
        kb_req = 1'b1; kb_addr = 10'h3FF; kb_data = 8'h1C;
        sb.push_back('{2'd2, 1'b0, 16'h0000});
        for (int c = 1; c <= 5; c++) begin
            step();
            if (mem_we) n_we++;
            if (kb_ack) n_ack++;
            if (c == 1) begin
                checks++;
                if (mem_addr !== 10'h3FF || mem_wdata !== 16'h001C
                    || mem_we !== 1'b1 || owner !== 2'd2) begin
                    errors++;
                    $display("FAIL kb_access got %h %h we %b own %0d exp 3ff 001c 1 2",
                             mem_addr, mem_wdata, mem_we, owner);
                end
            end
        end
        checks += 3;
        if (n_we != 1 || n_ack != 1) begin
            errors++;
            $display("FAIL kb_pulses got we %0d ack %0d exp 1 1", n_we, n_ack);
        end
        if (vga_rdata !== 16'hA028 || cpu_rdata !== 16'hA029) begin
            errors++;
            $display("FAIL kb_rdata_hold got %h %h exp a028 a029", vga_rdata, cpu_rdata);
        end
        if (mem[10'h3FF] !== 16'h001C) begin
            errors++;
            $display("FAIL kb_mem got %h exp 001c", mem[10'h3FF]);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int n_ack = 0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if ({busy, owner, vga_ack, kb_ack, cpu_ack, mem_we} !== 7'd0) begin
            errors++;
            $display("FAIL mid_ctrl got %b exp 0",
                     {busy, owner, vga_ack, kb_ack, cpu_ack, mem_we});
        end
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_mem got %h %h exp 0", mem_addr, mem_wdata);
        end
        if ({vga_rdata, cpu_rdata} !== 32'd0) begin
            errors++;
            $display("FAIL mid_rdata got %h %h exp 0", vga_rdata, cpu_rdata);
        end
        step();
        if (cpu_ack) n_ack++;
        step();
        if (cpu_ack) n_ack++;
        reset = 1'b1;
        c0 = cyc;
        g_own.delete();
        g_cyc.delete();
        sb.push_back('{2'd3, 1'b1, 16'hBEEF});
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (busy !== (c <= 3) || cpu_ack !== (c == 3)) begin
                errors++;
                $display("FAIL mid_fresh c%0d got busy %b ack %b exp %b %b",
                         c, busy, cpu_ack, c <= 3, c == 3);
            end
        end
        checks += 2;
        if (n_ack != 0) begin
            errors++;
            $display("FAIL mid_noack got %0d exp 0", n_ack);
        end
        if (g_cyc.size() != 1 || g_cyc[0] != c0 || cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL mid_grant got %0d grants rdata %h exp 1 at %0d beef",
                     g_cyc.size(), cpu_rdata, c0);
        end
    endtask

    task automatic test_cpu_pulse();
        int n_ack = 0;
        step();
        g_own.delete();
        g_cyc.delete();
        vga_req = 1'b1; vga_addr = 10'd10;
        sb.push_back('{2'd1, 1'b1, 16'hA00A});
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd7;
        step();
        cpu_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (cpu_ack) n_ack++;
        end
        checks += 3;
        if (g_own.size() != 1 || g_own[0] !== 2'd1) begin
            errors++;
            $display("FAIL pulse_grants got %0d exp 1 vga", g_own.size());
        end
        if (n_ack != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_noack got ack %0d busy %b exp 0 0", n_ack, busy);
        end
        if (dut.r_cpu_wait !== 3'd0) begin
            errors++;
            $display("FAIL pulse_wait got %0d exp 0", dut.r_cpu_wait);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_priority();
        test_starvation();
        test_kb_write();
        test_reset_mid();
        test_cpu_pulse();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
